find_min_n_vals_seq: RTL and testbench



---
 rtl/find_min_n_vals_seq_pkg.sv | 23 ++
 rtl/find_min_n_vals_seq_if.sv | 32 +++
 rtl/find_min_n_vals_seq_min_compare_step.sv | 31 +++
 rtl/find_min_n_vals_seq.sv | 135 +++++++++++++
 tb/tb_find_min_n_vals_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/find_min_n_vals_seq_pkg.sv
// ============================================================================
// Module   : find_min_n_vals_seq_pkg
// Brief    : Shared constants and FSM encoding for the sequential min finder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package find_min_n_vals_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int C_NO_INDEX      = 0;
    // Sweep geometry shared with the ultrasound sweep sequencer.
    localparam int C_DEFAULT_N     = 5;
    localparam int C_DEFAULT_WIDTH = 8;

endpackage : find_min_n_vals_seq_pkg

`default_nettype wire

// File: rtl/find_min_n_vals_seq_if.sv
// ============================================================================
// Module   : find_min_n_vals_seq_if
// Brief    : Reading stream in, scan result out, for the sequential min finder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface find_min_n_vals_seq_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_value;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] min_value;
    logic [IDX_W-1:0] min_index;
    logic             none_valid;

    modport master (
        output start, in_valid, in_value,
        input  busy, done, min_value, min_index, none_valid
    );

    modport slave (
        input  start, in_valid, in_value,
        output busy, done, min_value, min_index, none_valid
    );
endinterface : find_min_n_vals_seq_if

`default_nettype wire

// File: rtl/find_min_n_vals_seq_min_compare_step.sv
// ============================================================================
// Module   : min_compare_step
// Brief    : Decides whether a candidate reading replaces the running minimum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module min_compare_step
    import find_min_n_vals_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = 8,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  wire logic [WIDTH-1:0] i_cand_val,
    input  wire logic             i_cand_valid,
    input  wire logic [WIDTH-1:0] i_best_val,
    input  wire logic [IDX_W-1:0] i_best_idx,
    output logic                  o_take_new
);
    logic w_usable;
    logic w_no_best;

    assign w_usable  = i_cand_valid && !(SKIP_ZERO && (i_cand_val == '0));
    // Empty best wins unconditionally so an all-ones reading is still reported.
    assign w_no_best = (i_best_idx == IDX_W'(C_NO_INDEX));
    assign o_take_new = w_usable && (w_no_best || (i_cand_val < i_best_val));

endmodule : min_compare_step

`default_nettype wire

// File: rtl/find_min_n_vals_seq.sv
// ============================================================================
// Module   : find_min_n_vals_seq
// Brief    : Streams N range readings and reports the minimum and its index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module find_min_n_vals_seq
    import find_min_n_vals_seq_pkg::*;
#(
    parameter int WIDTH     = C_DEFAULT_WIDTH,
    parameter int N         = C_DEFAULT_N,
    parameter int IDX_W     = 8,
    parameter bit SKIP_ZERO = 1'b1
) (
    input wire logic              clock,
    input wire logic              reset,
    find_min_n_vals_seq_if.slave  bus
);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N);
    localparam logic [IDX_W-1:0] C_NO_IDX   = IDX_W'(C_NO_INDEX);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] min_value_q, min_value_d;
    logic [IDX_W-1:0] min_index_q, min_index_d;
    logic             none_valid_q, none_valid_d;

    logic             w_take_new;
    logic [IDX_W-1:0] w_next_idx;

    assign w_next_idx = cnt_q + 1'b1;

    min_compare_step #(
        .WIDTH     (WIDTH),
        .IDX_W     (IDX_W),
        .SKIP_ZERO (SKIP_ZERO)
    ) u_cmp (
        .i_cand_val   (bus.in_value),
        .i_cand_valid (bus.in_valid),
        .i_best_val   (best_val_q),
        .i_best_idx   (best_idx_q),
        .o_take_new   (w_take_new)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        min_value_d  = min_value_q;
        min_index_d  = min_index_q;
        none_valid_d = none_valid_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                best_val_d = '1;
                best_idx_d = C_NO_IDX;
                busy_d     = 1'b0;
                if (bus.start) begin
                    state_d = ST_SCAN;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                busy_d = 1'b1;
                if (bus.in_valid) begin
                    cnt_d = w_next_idx;
                    if (w_take_new) begin
                        best_val_d = bus.in_value;
                        best_idx_d = w_next_idx;
                    end
                    // Outputs are loaded with the merged best so they are
                    // already valid during the single REPORT cycle.
                    if (w_next_idx == C_LAST_IDX) begin
                        state_d      = ST_REPORT;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        min_value_d  = best_val_d;
                        min_index_d  = best_idx_d;
                        none_valid_d = (best_idx_d == C_NO_IDX);
                    end
                end
            end
            ST_REPORT: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            best_val_q   <= '1;
            best_idx_q   <= C_NO_IDX;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            min_value_q  <= '1;
            min_index_q  <= C_NO_IDX;
            none_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            min_value_q  <= min_value_d;
            min_index_q  <= min_index_d;
            none_valid_q <= none_valid_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.min_value  = min_value_q;
    assign bus.min_index  = min_index_q;
    assign bus.none_valid = none_valid_q;

endmodule : find_min_n_vals_seq

`default_nettype wire

// File: tb/tb_find_min_n_vals_seq.sv
// ============================================================================
// Module   : tb_find_min_n_vals_seq
// Brief    : Directed vectors against SKIP_ZERO=1 and SKIP_ZERO=0 instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_find_min_n_vals_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    find_min_n_vals_seq_if #(.WIDTH(8), .IDX_W(8)) bus0 ();
    find_min_n_vals_seq_if #(.WIDTH(8), .IDX_W(8)) bus1 ();

    assign bus1.start    = bus0.start;
    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_value = bus0.in_value;

    find_min_n_vals_seq #(.WIDTH(8), .N(5), .IDX_W(8), .SKIP_ZERO(1'b1)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    find_min_n_vals_seq #(.WIDTH(8), .N(5), .IDX_W(8), .SKIP_ZERO(1'b0)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        string          name;
        logic [0:4][7:0] vals;
        int             gap2;
        int             val0, idx0, none0;
        int             val1, idx1, none1;
    } vec_t;

    vec_t vecs[6];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_res(input string tag, input int v0, input int i0, input int n0,
                           input int v1, input int i1, input int n1);
        chk({tag, " dut0.min_value"},  int'(bus0.min_value),  v0);
        chk({tag, " dut0.min_index"},  int'(bus0.min_index),  i0);
        chk({tag, " dut0.none_valid"}, int'(bus0.none_valid), n0);
        chk({tag, " dut1.min_value"},  int'(bus1.min_value),  v1);
        chk({tag, " dut1.min_index"},  int'(bus1.min_index),  i1);
        chk({tag, " dut1.none_valid"}, int'(bus1.none_valid), n1);
    endtask

    task automatic run_scan(input vec_t v);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk({v.name, " busy after start"}, int'(bus0.busy), 1);
        for (int i = 0; i < 5; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_value = v.vals[i];
            tick();
            if (i < 4) chk({v.name, " early done"}, int'(bus0.done | bus1.done), 0);
            if (i == 1) begin
                for (int g = 0; g < v.gap2; g++) begin
                    bus0.in_valid = 1'b0;
                    bus0.in_value = 8'd1;
                    tick();
                    chk({v.name, " busy in gap"}, int'(bus0.busy), 1);
                end
            end
        end
        bus0.in_valid = 1'b0;
        chk({v.name, " done"}, int'(bus0.done & bus1.done), 1);
        chk({v.name, " busy in report"}, int'(bus0.busy), 0);
        chk_res(v.name, v.val0, v.idx0, v.none0, v.val1, v.idx1, v.none1);
        tick();
        chk({v.name, " done pulse"}, int'(bus0.done | bus1.done), 0);
        chk_res({v.name, " hold"}, v.val0, v.idx0, v.none0, v.val1, v.idx1, v.none1);
    endtask

    initial begin
        vecs[0] = '{"ascending",  '{8'd15, 8'd30, 8'd45, 8'd60, 8'd75}, 0,  15, 1, 0,  15, 1, 0};
        vecs[1] = '{"descending", '{8'd75, 8'd60, 8'd45, 8'd30, 8'd15}, 2,  15, 5, 0,  15, 5, 0};
        vecs[2] = '{"ties_zeros", '{8'd40, 8'd0,  8'd20, 8'd20, 8'd0 }, 0,  20, 3, 0,   0, 2, 0};
        vecs[3] = '{"all_zero",   '{8'd0,  8'd0,  8'd0,  8'd0,  8'd0 }, 0, 255, 0, 1,   0, 1, 0};
        vecs[4] = '{"after_zero", '{8'd9,  8'd8,  8'd7,  8'd6,  8'd5 }, 0,   5, 5, 0,   5, 5, 0};
        vecs[5] = '{"all_ones",   '{8'd255,8'd255,8'd255,8'd255,8'd255}, 1, 255, 1, 0, 255, 1, 0};

        bus0.start    = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.in_value = 8'd0;
        reset = 1'b1;
        tick();
        tick();
        chk("reset busy", int'(bus0.busy | bus1.busy), 0);
        chk("reset done", int'(bus0.done | bus1.done), 0);
        chk_res("reset", 255, 0, 0, 255, 0, 0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) run_scan(vecs[k]);

        // IDLE readings and a start coinciding with a reading are not accepted.
        bus0.in_valid = 1'b1;
        bus0.in_value = 8'd1;
        tick();
        tick();
        chk("idle reading busy", int'(bus0.busy), 0);
        chk("idle reading done", int'(bus0.done), 0);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.in_value = 8'd50;
        tick();
        bus0.in_value = 8'd40;
        tick();
        bus0.in_valid = 1'b0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_value = 8'd30;
        tick();
        bus0.start = 1'b1;
        bus0.in_value = 8'd20;
        tick();
        bus0.start = 1'b0;
        chk("start mid-scan no done", int'(bus0.done), 0);
        bus0.in_value = 8'd10;
        tick();
        bus0.in_valid = 1'b0;
        chk("hazard done", int'(bus0.done), 1);
        chk_res("hazard", 10, 5, 0, 10, 5, 0);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk("start in report ignored", int'(bus0.busy), 0);
        tick();
        chk("still idle", int'(bus0.busy | bus0.done), 0);

        // Reset mid-scan discards partial results.
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.in_value = 8'(3 - i);
            tick();
        end
        bus0.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset busy", int'(bus0.busy | bus1.busy), 0);
        chk("midreset done", int'(bus0.done | bus1.done), 0);
        chk_res("midreset", 255, 0, 0, 255, 0, 0);
        bus0.in_valid = 1'b1;
        bus0.in_value = 8'd2;
        tick();
        tick();
        bus0.in_valid = 1'b0;
        chk("post-reset no done", int'(bus0.done | bus0.busy), 0);
        run_scan(vecs[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_find_min_n_vals_seq

`default_nettype wire
